// File: rtl/lsu_pkg.sv
// Shared types and helpers for the dmem_lsu load/store unit: FSM states,
// RV32I load/store size codes and the load-data extraction/extension function.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   function automatic logic f3_legal(input logic [2:0] funct3);
      return (funct3 == F3_LB)  || (funct3 == F3_LH) || (funct3 == F3_LW) ||
             (funct3 == F3_LBU) || (funct3 == F3_LHU);
   endfunction

   // Shift the addressed byte/half down to bit 0, then sign- or zero-extend.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  funct3);
      logic [31:0] w_lane;
      w_lane = word >> {off, 3'b000};
      case (funct3)
         F3_LB:   load_extend = {{24{w_lane[7]}}, w_lane[7:0]};
         F3_LH:   load_extend = {{16{w_lane[15]}}, w_lane[15:0]};
         F3_LBU:  load_extend = {24'h0, w_lane[7:0]};
         F3_LHU:  load_extend = {16'h0, w_lane[15:0]};
         default: load_extend = word;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for dmem_lsu: byte enables, replicated store data, load offset.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of aligning them down.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [1:0]  o_off,
   output logic        o_misalign
);

   always_comb begin
      // NOTE: every output gets a default first, so no branch can infer a latch.
      o_be       = 4'hF;
      o_wdata    = i_wdata;
      o_off      = 2'b00;
      o_misalign = 1'b0;
      case (i_funct3)
         F3_LB, F3_LBU: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
            o_off   = i_addr_lo;
         end
         F3_LH, F3_LHU: begin
            o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_wdata = {2{i_wdata[15:0]}};
            o_off   = {i_addr_lo[1], 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
            o_misalign = i_addr_lo[0];
`endif
         end
         F3_LW: begin
`ifdef LSU_MISALIGN_TRAP_EN
            o_misalign = |i_addr_lo;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between a single-cycle core and a req/gnt/rvalid data memory.
// Misaligned accesses trap when LSU_MISALIGN_TRAP_EN is defined (see lsu_align).
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   lsu_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_funct3;
   logic [1:0]       r_off;
   logic             r_mem_req;
   logic             r_mem_we;
   logic [31:0]      r_mem_addr;
   logic [3:0]       r_mem_be;
   logic [31:0]      r_mem_wdata;
   logic             r_rsp_valid;
   logic             r_rsp_err;
   logic [31:0]      r_rsp_rdata;

   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [1:0]       w_off;
   logic             w_misalign;
   logic             w_reject;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_timeout;

   lsu_align u_align (
      .i_funct3   (req_funct3),
      .i_addr_lo  (req_addr[1:0]),
      .i_wdata    (req_wdata),
      .o_be       (w_be),
      .o_wdata    (w_wdata),
      .o_off      (w_off),
      .o_misalign (w_misalign)
   );

   assign w_reject  = ~f3_legal(req_funct3) | w_misalign;
   assign w_cnt_nxt = r_cnt + 1'b1;
   // The cycle that reaches the limit aborts, even if gnt/rvalid shows up in it.
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_funct3    <= '0;
         r_off       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_funct3    <= req_funct3;
                  r_off       <= w_off;
                  r_mem_we    <= req_we;
                  r_mem_addr  <= {req_addr[31:2], 2'b00};
                  r_mem_be    <= w_be;
                  r_mem_wdata <= w_wdata;
                  r_cnt       <= '0;
                  if (w_reject) begin
                     r_state     <= DONE;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                  end else begin
                     r_state   <= REQ;
                     r_mem_req <= 1'b1;
                  end
               end
            end
            REQ: begin
               r_cnt <= w_cnt_nxt;
               if (w_timeout) begin
                  r_state     <= DONE;
                  r_mem_req   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
               end else if (mem_gnt) begin
                  r_mem_req <= 1'b0;
                  if (r_mem_we) begin
                     r_state     <= DONE;
                     r_rsp_valid <= 1'b1;
                  end else begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               r_cnt <= w_cnt_nxt;
               if (w_timeout) begin
                  r_state     <= DONE;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
               end else if (mem_rvalid) begin
                  r_state     <= DONE;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= load_extend(mem_rdata, r_off, r_funct3);
               end
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign stall     = req_valid & ~r_rsp_valid;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed cases plus randomized traffic, with expected
// lanes, data, errors and latency computed from byte-level arithmetic.
module tb_dmem_lsu;

   localparam int T_OUT = 8;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   dmem_lsu #(.TIMEOUT_CYCLES(T_OUT), .CNT_W(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed=still running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access from acceptance to response. gnt_dly<0: memory never grants.
   task automatic run_txn(input string tag, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rword);
      int          size, off, ev, exp_lat, exp_reqs, cyc, req_cyc, gnt_cyc;
      bit          rej, exp_err, granted, done;
      logic [31:0] mask, raw, exp_wdata, exp_rdata;
      logic [3:0]  exp_be;

      size = 1 << f3[1:0];
      rej  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      off  = (int'(addr % 4) / size) * size;
`ifdef LSU_MISALIGN_TRAP_EN
      if ((int'(addr % 4) % size) != 0) rej = 1'b1;
`endif
      exp_be = 4'(((32'h1 << size) - 1) << off);
      case (size)
         1:       exp_wdata = {24'h0, wd[7:0]} * 32'h0101_0101;
         2:       exp_wdata = {16'h0, wd[15:0]} * 32'h0001_0001;
         default: exp_wdata = wd;
      endcase
      mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
      raw  = (rword >> (8 * off)) & mask;
      exp_rdata = raw;
      if (!f3[2] && size < 4 && raw[8 * size - 1]) exp_rdata = raw | ~mask;

      if (rej) begin
         exp_lat = 1; exp_err = 1'b1; exp_reqs = 0;
      end else begin
         ev = (gnt_dly < 0) ? 1000 : (we ? 1 + gnt_dly : 1 + gnt_dly + rv_dly);
         exp_err  = (ev >= T_OUT);
         exp_lat  = exp_err ? T_OUT + 1 : ev + 1;
         exp_reqs = (gnt_dly < 0 || gnt_dly + 1 >= T_OUT) ? T_OUT : gnt_dly + 1;
      end
      if (we || exp_err) exp_rdata = 32'h0;

      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      cyc = 0; req_cyc = 0; gnt_cyc = 0; granted = 1'b0; done = 1'b0;
      while (!done && cyc <= exp_lat + 4) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (mem_req === 1'b1) begin
            check({tag, ":mem_addr"}, mem_addr, {addr[31:2], 2'b00});
            check({tag, ":mem_be"}, 32'(mem_be), 32'(exp_be));
            check({tag, ":mem_we"}, 32'(mem_we), 32'(we));
            if (we) check({tag, ":mem_wdata"}, mem_wdata, exp_wdata);
            mem_rvalid = 1'($urandom_range(0, 1));
            if (gnt_dly >= 0 && req_cyc == gnt_dly) begin
               mem_gnt = 1'b1; granted = 1'b1; gnt_cyc = cyc;
            end
            req_cyc++;
         end else if (granted && !we && (cyc - gnt_cyc) == rv_dly) begin
            mem_rvalid = 1'b1; mem_rdata = rword;
         end
         #4;
         check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(cyc == exp_lat));
         check({tag, ":stall"}, 32'(stall), 32'(cyc != exp_lat));
         if (rsp_valid === 1'b1) begin
            done = 1'b1;
            check({tag, ":rsp_err"}, 32'(rsp_err), 32'(exp_err));
            check({tag, ":rsp_rdata"}, rsp_rdata, exp_rdata);
         end
         @(posedge clk); #1;
         cyc++;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0; req_valid = 1'b0;
      check({tag, ":responded"}, 32'(done), 32'(1));
      check({tag, ":req_cycles"}, 32'(req_cyc), 32'(exp_reqs));
   endtask

   initial begin
      logic [2:0]  f3;
      bit          we;
      int          g, rv;

      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst:mem_req", 32'(mem_req), 32'(0));
      check("rst:rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst:rsp_err", 32'(rsp_err), 32'(0));
      check("rst:rsp_rdata", rsp_rdata, 32'h0);
      check("rst:mem_we", 32'(mem_we), 32'(0));
      check("rst:mem_addr", mem_addr, 32'h0);
      check("rst:mem_be", 32'(mem_be), 32'(0));
      check("rst:mem_wdata", mem_wdata, 32'h0);
      check("rst:stall", 32'(stall), 32'(0));
      #2 reset_n = 1'b1;
      @(posedge clk); #1;

      run_txn("sw100",      1'b1, 3'b010, 32'd100,  32'h0000_0019, 0, 1, 32'h0);
      run_txn("sb61",       1'b1, 3'b000, 32'h61,   32'h0000_00AB, 0, 1, 32'h0);
      run_txn("lb61",       1'b0, 3'b000, 32'h61,   32'h0,         0, 1, 32'h0000_AB00);
      run_txn("lbu61",      1'b0, 3'b100, 32'h61,   32'h0,         0, 1, 32'h0000_AB00);
      run_txn("lh62_dly5",  1'b0, 3'b001, 32'h62,   32'h0,         5, 1, 32'h8001_0000);
      run_txn("lhu62",      1'b0, 3'b101, 32'h62,   32'h0,         1, 2, 32'h8001_0000);
      run_txn("sh_hi",      1'b1, 3'b001, 32'h1A,   32'hCAFE_BEEF, 2, 1, 32'h0);
      run_txn("sw_nognt",   1'b1, 3'b010, 32'h200,  32'h1234_5678, -1, 1, 32'h0);
      run_txn("lw_norv",    1'b0, 3'b010, 32'h204,  32'h0,         2, 50, 32'h0);
      run_txn("lw_gnt_to",  1'b0, 3'b010, 32'h208,  32'h0,         T_OUT - 1, 1, 32'h5555_AAAA);
      run_txn("sw_last_ok", 1'b1, 3'b010, 32'h20C,  32'h0F0F_0F0F, T_OUT - 2, 1, 32'h0);
      run_txn("lw65",       1'b0, 3'b010, 32'h65,   32'h0,         1, 2, 32'hDEAD_BEEF);
      run_txn("ill011",     1'b0, 3'b011, 32'h40,   32'h0,         0, 1, 32'hFFFF_FFFF);
      run_txn("ill111_st",  1'b1, 3'b111, 32'h44,   32'h1,         0, 1, 32'h0);

      // Reset while the request is outstanding: mem_req must drop without a clock edge.
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
      @(posedge clk); #1;
      check("rstREQ:mem_req_before", 32'(mem_req), 32'(1));
      #2 reset_n = 1'b0;
      #1;
      check("rstREQ:mem_req", 32'(mem_req), 32'(0));
      check("rstREQ:rsp_valid", 32'(rsp_valid), 32'(0));
      req_valid = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // Reset in WAIT, then a stale rvalid/gnt must produce nothing.
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h304;
      @(posedge clk); #1;
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("rstWAIT:mem_req", 32'(mem_req), 32'(0));
      check("rstWAIT:rsp_valid", 32'(rsp_valid), 32'(0));
      req_valid = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         #4;
         check($sformatf("rstWAIT:stale_rsp%0d", i), 32'(rsp_valid), 32'(0));
         check($sformatf("rstWAIT:stale_req%0d", i), 32'(mem_req), 32'(0));
         @(posedge clk); #1;
         mem_rvalid = 1'b0; mem_gnt = 1'b0;
      end
      run_txn("after_rst", 1'b0, 3'b000, 32'h303, 32'h0, 0, 1, 32'h7F00_0000);

      for (int n = 0; n < 200; n++) begin
         f3 = 3'($urandom_range(0, 7));
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 11) == 0) g = -1;
         else if ($urandom_range(0, 5) == 0) g = int'($urandom_range(4, 8));
         else g = int'($urandom_range(0, 3));
         rv = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(1, 3));
         run_txn($sformatf("rnd%0d", n), we, f3, $urandom, $urandom, g, rv, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
